// File: rtl/gate_window_timer_pkg.sv
// Shared state encoding for the gate-window timer.
package gate_window_timer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_GATE   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_CLEAR  = ST_CLEAR,
        S_GATE   = ST_GATE,
        S_SETTLE = ST_SETTLE,
        S_DONE   = ST_DONE
    } gwt_state_t;

endpackage

// File: rtl/window_down_counter.sv
// Loadable down counter holding the gate cycles left; is_one is registered
// alongside the count so the FSM can close the gate without a compare path.
module window_down_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);

    logic [WIDTH-1:0] count_nxt;

    // Decrement saturates at zero so the count can never wrap.
    always_comb begin
        count_nxt = count;
        if (clear)
            count_nxt = '0;
        else if (load)
            count_nxt = load_val;
        else if (dec && count != '0)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            is_one <= 1'b0;
        end else begin
            count  <= count_nxt;
            is_one <= (count_nxt == WIDTH'(1));
        end
    end

endmodule

// File: rtl/gate_window_timer.sv
// Gate-window generator for the ring-oscillator event counters.
// Optional auto-repeat from DONE is enabled by defining GATE_WINDOW_TIMER_REPEAT_EN.
module gate_window_timer
    import gate_window_timer_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] window_len,
`ifdef GATE_WINDOW_TIMER_REPEAT_EN
    input  logic             repeat_en,
`endif
    output logic             gate_out,
    output logic             count_clear,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    gwt_state_t       state;
    logic [WIDTH-1:0] len_q;
    logic [SW-1:0]    settle_cnt;
    logic             is_one;
    logic             rep;
    logic             cnt_clear;
    logic             cnt_load;
    logic             cnt_dec;

`ifdef GATE_WINDOW_TIMER_REPEAT_EN
    assign rep = repeat_en;
`else
    assign rep = 1'b0;
`endif

    assign cnt_clear = abort && (state != S_IDLE);
    assign cnt_load  = (state == S_CLEAR);
    assign cnt_dec   = (state == S_GATE);

    window_down_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (len_q),
        .count    (remaining),
        .is_one   (is_one)
    );

    // Outputs are decoded from the state being entered so they are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            len_q       <= '0;
            settle_cnt  <= '0;
            gate_out    <= 1'b0;
            count_clear <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            gate_out    <= 1'b0;
            count_clear <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state       <= S_CLEAR;
                            len_q       <= window_len;
                            count_clear <= 1'b1;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    S_CLEAR: begin
                        if (len_q == '0) begin
                            state      <= S_SETTLE;
                            settle_cnt <= SW'(SETTLE - 1);
                        end else begin
                            state    <= S_GATE;
                            gate_out <= 1'b1;
                        end
                    end
                    S_GATE: begin
                        if (is_one) begin
                            state      <= S_SETTLE;
                            settle_cnt <= SW'(SETTLE - 1);
                        end else begin
                            gate_out <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (rep) begin
                            state       <= S_CLEAR;
                            count_clear <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
